arm_multicycle_controller: RTL and testbench



---
 rtl/arm_multicycle_controller.sv | 214 +++++++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : arm_multicycle_controller
//  Brief    : Control unit for the multicycle ARM core. Main FSM
//             (FETCH/DECODE/execute/writeback), ALU decoder, condition
//             check and NZCV flag register.
//  Revision : 1.0 - initial release
// ============================================================================
module arm_multicycle_controller #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUControl,
    output logic         shift_flag,
    output logic [3:0]   State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next;
    state_t      w_dec_state;
    logic [3:0]  r_flags;
    logic        r_cond_ex_q;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_rd15;
    logic        w_unused_rn;

    logic        w_nextpc, w_branch, w_regw, w_memw, w_irw, w_aluop;
    logic [1:0]  w_dp_ctl, w_dp_flagw, w_flagw;
    logic        w_dp_nowrite, w_dp_shift, w_nowrite;
    logic        w_cond_ex;
    logic        w_n, w_z, w_c, w_v;

    assign w_cond      = Instr[31:28];
    assign w_op        = Instr[27:26];
    assign w_funct     = Instr[25:20];
    assign w_rd15      = (Instr[15:12] == 4'hF);
    assign w_unused_rn = &{1'b0, Instr[19:16]};
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next-state sequencing
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    2'b00:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;   // undefined opcode runs as a NOP
                endcase
            end
            S_MEMADR:   w_next = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; during reset the outputs decode as FETCH
    always_comb begin
        w_dec_state = reset ? S_FETCH : r_state;
        w_nextpc  = 1'b0;
        w_branch  = 1'b0;
        w_regw    = 1'b0;
        w_memw    = 1'b0;
        w_irw     = 1'b0;
        w_aluop   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        case (w_dec_state)
            S_FETCH: begin
                w_irw = 1'b1; w_nextpc = 1'b1;
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01; w_regw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1; w_memw = 1'b1;
            end
            S_EXECUTER: w_aluop = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01; w_aluop = 1'b1;
            end
            S_ALUWB:    w_regw = 1'b1;
            S_BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10; w_branch = 1'b1;
            end
            default: ;
        endcase
    end

    // Data-processing command decode from Funct[4:1], S = Funct[0]
    always_comb begin
        w_dp_ctl     = 2'b00;
        w_dp_flagw   = 2'b00;
        w_dp_nowrite = 1'b0;
        w_dp_shift   = 1'b0;
        case (w_funct[4:1])
            4'b0100: begin w_dp_ctl = 2'b00; w_dp_flagw = w_funct[0] ? 2'b11 : 2'b00; end
            4'b0010: begin w_dp_ctl = 2'b01; w_dp_flagw = w_funct[0] ? 2'b11 : 2'b00; end
            4'b0000: begin w_dp_ctl = 2'b10; w_dp_flagw = w_funct[0] ? 2'b10 : 2'b00; end
            4'b1100: begin w_dp_ctl = 2'b11; w_dp_flagw = w_funct[0] ? 2'b10 : 2'b00; end
            4'b1010: begin w_dp_ctl = 2'b01; w_dp_flagw = 2'b11; w_dp_nowrite = 1'b1; end
            4'b1101: begin
                w_dp_ctl = 2'b00; w_dp_shift = 1'b1;
                w_dp_flagw = w_funct[0] ? 2'b10 : 2'b00;
            end
            default: w_dp_nowrite = 1'b1;
        endcase
    end

    // ALU controls only apply while executing; NoWrite is a property of the
    // data-processing instruction itself, so it stays valid into ALUWB
    assign ALUControl = w_aluop ? w_dp_ctl   : 2'b00;
    assign w_flagw    = w_aluop ? w_dp_flagw : 2'b00;
    assign shift_flag = w_aluop & w_dp_shift;
    assign w_nowrite  = (w_op == 2'b00) & w_dp_nowrite;

    // Condition check against the registered NZCV flags
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'h0: w_cond_ex = w_z;
            4'h1: w_cond_ex = ~w_z;
            4'h2: w_cond_ex = w_c;
            4'h3: w_cond_ex = ~w_c;
            4'h4: w_cond_ex = w_n;
            4'h5: w_cond_ex = ~w_n;
            4'h6: w_cond_ex = w_v;
            4'h7: w_cond_ex = ~w_v;
            4'h8: w_cond_ex = w_c & ~w_z;
            4'h9: w_cond_ex = ~(w_c & ~w_z);
            4'hA: w_cond_ex = (w_n == w_v);
            4'hB: w_cond_ex = (w_n != w_v);
            4'hC: w_cond_ex = ~w_z & (w_n == w_v);
            4'hD: w_cond_ex = w_z | (w_n != w_v);
            4'hE: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Condition outcome frozen at the end of DECODE for the whole instruction
    always_ff @(posedge clk) begin
        if (reset)                   r_cond_ex_q <= 1'b0;
        else if (r_state == S_DECODE) r_cond_ex_q <= w_cond_ex;
    end

    // NZCV register, written only at the end of a passing execute cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= FLAGS_RESET;
        end else if (((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) && r_cond_ex_q) begin
            if (w_flagw[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (w_flagw[0]) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Write gating; R15 destinations go through the PC enable only
    assign PCWrite  = (w_nextpc | ((w_branch | (w_regw & w_rd15)) & r_cond_ex_q)) & ~reset;
    assign RegWrite = w_regw & ~w_nowrite & r_cond_ex_q & ~(w_rd15 & ~w_branch) & ~reset;
    assign MemWrite = w_memw & r_cond_ex_q & ~reset;
    assign IRWrite  = w_irw & ~reset;

    assign ImmSrc = w_op;
    assign RegSrc = {(w_op == 2'b01), (w_op == 2'b10)};
    assign State  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_arm_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arm_multicycle_controller
//  Brief    : Scoreboard bench for arm_multicycle_controller. A driver walks
//             each instruction through its expected path, pushing the
//             expected control word per cycle; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arm_multicycle_controller;

    localparam logic [3:0] c_flags_reset = 4'b0000;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [1:0] rsrc;
        logic [1:0] alu;
        logic       sh;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic        ALUSrcA, shift_flag;
    logic [3:0]  State;

    int   tests = 0;
    int   fails = 0;
    rec_t q[$];
    logic [3:0] flags_m = c_flags_reset;

    arm_multicycle_controller #(.FLAGS_RESET(c_flags_reset)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .shift_flag(shift_flag), .State(State)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit cond_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;            4'h1: return !z;
            4'h2: return c;            4'h3: return !c;
            4'h4: return n;            4'h5: return !n;
            4'h6: return v;            4'h7: return !v;
            4'h8: return c && !z;      4'h9: return !c || z;
            4'hA: return n == v;       4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void dp_info(input logic [5:0] funct, output logic [1:0] ctl,
                                    output bit nw, output bit sh, output logic [1:0] fw);
        bit s;
        s = funct[0]; nw = 0; sh = 0; ctl = 2'b00; fw = 2'b00;
        case (funct[4:1])
            4'b0100: begin ctl = 2'b00; fw = s ? 2'b11 : 2'b00; end
            4'b0010: begin ctl = 2'b01; fw = s ? 2'b11 : 2'b00; end
            4'b0000: begin ctl = 2'b10; fw = s ? 2'b10 : 2'b00; end
            4'b1100: begin ctl = 2'b11; fw = s ? 2'b10 : 2'b00; end
            4'b1010: begin ctl = 2'b01; fw = 2'b11; nw = 1; end
            4'b1101: begin ctl = 2'b00; sh = 1; fw = s ? 2'b10 : 2'b00; end
            default: nw = 1;
        endcase
    endfunction

    function automatic rec_t base_rec(input int st, input logic [19:0] ins);
        rec_t r;
        r = '0;
        r.st   = 4'(st);
        r.imm  = ins[15:14];
        r.rsrc = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
        return r;
    endfunction

    // Outputs while reset is held: FETCH controls with every write blocked
    function automatic rec_t reset_rec(input int st, input logic [19:0] ins);
        rec_t r;
        r = base_rec(st, ins);
        r.srca = 1; r.srcb = 2'b10; r.res = 2'b10;
        return r;
    endfunction

    function automatic rec_t expect_rec(input int st, input logic [19:0] ins, input bit pass);
        rec_t r;
        logic [1:0] ctl, fw;
        bit nw, sh, rd15;
        r = base_rec(st, ins);
        rd15 = (ins[3:0] == 4'hF);
        dp_info(ins[13:8], ctl, nw, sh, fw);
        case (st)
            0: begin r.pcw = 1; r.irw = 1; r.srca = 1; r.srcb = 2'b10; r.res = 2'b10; end
            1: begin r.srca = 1; r.srcb = 2'b10; r.res = 2'b10; end
            2: r.srcb = 2'b01;
            3: r.adr = 1;
            4: begin r.res = 2'b01; r.regw = pass && !rd15; r.pcw = pass && rd15; end
            5: begin r.adr = 1; r.memw = pass; end
            6: begin r.alu = ctl; r.sh = sh; end
            7: begin r.srcb = 2'b01; r.alu = ctl; r.sh = sh; end
            8: begin r.regw = pass && !rd15 && !nw; r.pcw = pass && rd15; end
            default: begin r.srcb = 2'b01; r.res = 2'b10; r.pcw = pass; end
        endcase
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [19:0] ins, input logic [3:0] af, input rec_t e);
        @(posedge clk);
        #1;
        reset = r; Instr = ins; ALUFlags = af;
        q.push_back(e);
    endtask

    task automatic run_instr(input logic [19:0] ins, input int abort_at, input int rst_len,
                             input bit fix, input logic [3:0] faf);
        int path[$];
        bit pass;
        logic [1:0] op, ctl, fw;
        logic [3:0] af;
        bit nw, sh;
        op = ins[15:14];
        path = '{0, 1};
        case (op)
            2'b00: begin path.push_back(ins[13] ? 7 : 6); path.push_back(8); end
            2'b01: begin
                path.push_back(2);
                if (ins[8]) begin path.push_back(3); path.push_back(4); end
                else path.push_back(5);
            end
            2'b10: path.push_back(9);
            default: ;
        endcase
        pass = cond_pass(ins[19:16], flags_m);
        dp_info(ins[13:8], ctl, nw, sh, fw);
        for (int k = 0; k < path.size(); k++) begin
            if (k == abort_at) begin
                for (int r = 0; r < rst_len; r++)
                    drive(1'b1, ins, 4'($urandom_range(0, 15)), reset_rec(r == 0 ? path[k] : 0, ins));
                flags_m = c_flags_reset;
                return;
            end
            af = (fix && (path[k] == 6 || path[k] == 7)) ? faf : 4'($urandom_range(0, 15));
            drive(1'b0, ins, af, expect_rec(path[k], ins, pass));
            if ((path[k] == 6 || path[k] == 7) && pass) begin
                if (fw[1]) flags_m[3:2] = af[3:2];
                if (fw[0]) flags_m[1:0] = af[1:0];
            end
        end
    endtask

    // ---------------- monitor ----------------
    // Compare the DUT control word with the oldest expectation each cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t e, a;
            e = q.pop_front();
            a = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, shift_flag};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL ctrl t=%0t instr=%h: actual st=%0d pcw=%b adr=%b memw=%b irw=%b regw=%b res=%b srca=%b srcb=%b imm=%b rsrc=%b alu=%b sh=%b | required st=%0d pcw=%b adr=%b memw=%b irw=%b regw=%b res=%b srca=%b srcb=%b imm=%b rsrc=%b alu=%b sh=%b",
                         $time, Instr, a.st, a.pcw, a.adr, a.memw, a.irw, a.regw, a.res, a.srca, a.srcb, a.imm, a.rsrc, a.alu, a.sh,
                         e.st, e.pcw, e.adr, e.memw, e.irw, e.regw, e.res, e.srca, e.srcb, e.imm, e.rsrc, e.alu, e.sh);
            end
        end
    end

    // Hard time limit
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [19:0] ins;
        int len, ab;
        localparam logic [3:0] c_cmds [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1101};

        @(posedge clk);                                       // state known after first edge
        drive(1'b1, 20'h00000, 4'h0, reset_rec(0, 20'h00000));
        flags_m = c_flags_reset;

        // Directed sequence
        run_instr(20'hE5912, 3, 2, 0, 4'h0);                  // LDR aborted in MEMREAD
        run_instr(20'hE0812, -1, 0, 0, 4'h0);                 // ADD
        run_instr(20'hE5912, -1, 0, 0, 4'h0);                 // LDR
        run_instr(20'hE5812, -1, 0, 0, 4'h0);                 // STR
        run_instr(20'hE1510, -1, 0, 1, 4'b0100);              // CMP sets Z
        run_instr(20'h0A000, -1, 0, 0, 4'h0);                 // BEQ taken
        run_instr(20'hE1510, -1, 0, 1, 4'b0000);              // CMP clears Z
        run_instr(20'h0A000, -1, 0, 0, 4'h0);                 // BEQ not taken
        run_instr(20'hE0900, -1, 0, 1, 4'b1000);              // ADDS -> N
        run_instr(20'h00800, -1, 0, 1, 4'b0100);              // ADDEQ fails, flags held
        run_instr(20'h0A000, -1, 0, 0, 4'h0);                 // BEQ still not taken
        run_instr(20'hE1A00, -1, 0, 0, 4'h0);                 // MOV shift
        run_instr(20'hEC000, -1, 0, 0, 4'h0);                 // undefined op
        run_instr(20'hF0812, -1, 0, 0, 4'h0);                 // cond NV
        run_instr(20'hE081F, -1, 0, 0, 4'h0);                 // ADD to R15 -> PC write

        // Randomized instructions with occasional mid-instruction resets
        for (int i = 0; i < 400; i++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 3) != 0) ins[12:9] = c_cmds[$urandom_range(0, 5)];
            if ($urandom_range(0, 2) != 0) ins[19:16] = 4'hE;
            if ($urandom_range(0, 5) == 0) ins[3:0] = 4'hF;
            len = 5;
            ab  = ($urandom_range(0, 11) == 0) ? $urandom_range(0, len - 1) : -1;
            run_instr(ins, ab, $urandom_range(1, 2), 0, 4'h0);
        end

        repeat (2) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: actual %0d pending, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
